// File: rtl/probe_stim_pkg.sv
// Shared types and constants for the probe stimulus generator: pattern modes,
// FSM states, pattern width, LFSR tap mask and the burst seed selector.
package probe_stim_pkg;

  localparam int PAT_W = 16;
  localparam logic [PAT_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_WALK = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Pattern loaded on the IDLE->RUN edge; hold mode keeps whatever pat was.
  function automatic logic [PAT_W-1:0] seed_pat(input mode_e            m,
                                                input logic [PAT_W-1:0] cur,
                                                input logic [PAT_W-1:0] lfsr_seed);
    case (m)
      MODE_CNT:  return '0;
      MODE_LFSR: return lfsr_seed;
      MODE_WALK: return {{(PAT_W-1){1'b0}}, 1'b1};
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Next-state function of the 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1,
// shifting left with the XOR of the tapped bits fed into bit 0.
module lfsr16
  import probe_stim_pkg::*;
(
  input  logic [PAT_W-1:0] pat_i,
  output logic [PAT_W-1:0] pat_o
);

  logic feedback;

  assign feedback = ^(pat_i & LFSR_TAPS);
  assign pat_o    = {pat_i[PAT_W-2:0], feedback};

endmodule

// File: rtl/probe_stim_gen.sv
// Pattern-burst generator driving debug-core probes. SEED must be nonzero.
// Define PROBE_STIM_LFSR_EN to build the LFSR pattern; otherwise mode 1 is the counter.
module probe_stim_gen
  import probe_stim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  mode,
  input  logic [7:0]  prescale,
  input  logic [15:0] burst_len,
  output logic        probe0,
  output logic [3:0]  probe1,
  output logic [7:0]  probe2,
  output logic [15:0] probe3,
  output logic        busy,
  output logic        trig,
  output logic        done
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d, mode_sel;
  logic [7:0]         presc_q, presc_d;
  logic [7:0]         tick_q, tick_d;
  logic [15:0]        burst_q, burst_d;
  logic [15:0]        step_cnt_q, step_cnt_d;
  logic [PAT_W-1:0]   pat_q, pat_d, step_pat;
  logic               trig_q, trig_d;

`ifdef PROBE_STIM_LFSR_EN
  logic [PAT_W-1:0] lfsr_next;

  lfsr16 u_lfsr16 (
    .pat_i (pat_q),
    .pat_o (lfsr_next)
  );

  assign mode_sel = mode_e'(mode);
`else
  assign mode_sel = (mode_e'(mode) == MODE_LFSR) ? MODE_CNT : mode_e'(mode);
`endif

  // Value pat takes on a step edge for the latched mode.
  always_comb begin
    step_pat = pat_q;
    case (mode_q)
      MODE_CNT:  step_pat = pat_q + 16'd1;
`ifdef PROBE_STIM_LFSR_EN
      MODE_LFSR: step_pat = lfsr_next;
`endif
      MODE_WALK: step_pat = {pat_q[PAT_W-2:0], pat_q[PAT_W-1]};
      default:   step_pat = pat_q;
    endcase
  end

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    presc_d    = presc_q;
    burst_d    = burst_q;
    step_cnt_d = step_cnt_q;
    tick_d     = tick_q;
    pat_d      = pat_q;
    trig_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d    = ST_RUN;
          mode_d     = mode_sel;
          presc_d    = prescale;
          burst_d    = burst_len;
          step_cnt_d = '0;
          tick_d     = '0;
          pat_d      = seed_pat(mode_sel, pat_q, SEED);
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick_q == '0) begin
          pat_d      = step_pat;
          tick_d     = presc_q;
          step_cnt_d = (step_cnt_q == 16'hFFFF) ? step_cnt_q : step_cnt_q + 16'd1;
          trig_d     = (step_cnt_q == '0);
          // Step number burst_len is the one whose pre-step count is burst_len-1.
          if (burst_q != '0 && step_cnt_q == burst_q - 16'd1) begin
            state_d = ST_DONE;
          end
        end else begin
          tick_d = tick_q - 8'd1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: there is no memory array here, so every register is reset and the
    // probes read a known zero straight after reset.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_CNT;
      presc_q    <= '0;
      tick_q     <= '0;
      burst_q    <= '0;
      step_cnt_q <= '0;
      pat_q      <= '0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      burst_q    <= burst_d;
      step_cnt_q <= step_cnt_d;
      pat_q      <= pat_d;
      trig_q     <= trig_d;
    end
  end

  assign probe0 = pat_q[0];
  assign probe1 = pat_q[3:0];
  assign probe2 = pat_q[7:0];
  assign probe3 = pat_q;
  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign trig   = trig_q;

endmodule
